// File: rtl/bin2bcd_seq_if.sv
// Handshake and data bundle between the multiplier-side requester and the
// bin2bcd_seq converter.
interface bin2bcd_seq_if #(
    parameter int BIN_WIDTH = 16,
    parameter int DIGITS    = 5
);
    logic                  start;
    logic [BIN_WIDTH-1:0]  bin_in;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd_out;

    modport master (
        output start,
        output bin_in,
        input  busy,
        input  done,
        input  bcd_out
    );

    modport slave (
        input  start,
        input  bin_in,
        output busy,
        output done,
        output bcd_out
    );
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one correct-and-shift step per cycle,
// producing a packed BCD result every BIN_WIDTH+2 cycles.
module bin2bcd_seq #(
    parameter int BIN_WIDTH = 16,
    parameter int DIGITS    = 5
) (
    input  logic           clk,
    input  logic           rst_n,
    bin2bcd_seq_if.slave   bus
);
    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(BIN_WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(BIN_WIDTH - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t                state, state_nxt;
    logic [BW-1:0]         bcd_scr;
    logic [BIN_WIDTH-1:0]  bin_scr;
    logic [CW-1:0]         cnt;
    logic [BW-1:0]         bcd_res;
    logic [BW+BIN_WIDTH-1:0] step;
    logic                  accept;
    logic                  last_step;

    // Per-digit "add 3 when >= 5" so the following shift carries correctly.
    function automatic logic [BW-1:0] add3(input logic [BW-1:0] d);
        logic [BW-1:0] r;
        r = d;
        for (int i = 0; i < DIGITS; i++) begin
            if (d[4*i +: 4] >= 4'd5)
                r[4*i +: 4] = d[4*i +: 4] + 4'd3;
        end
        return r;
    endfunction

    assign step      = {add3(bcd_scr), bin_scr} << 1;
    assign accept    = (state == IDLE) && bus.start;
    assign last_step = (state == SHIFT) && (cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = SHIFT;
            SHIFT:   if (cnt == LAST) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcd_scr <= '0;
            bin_scr <= '0;
            cnt     <= '0;
            bcd_res <= '0;
        end else begin
            if (accept) begin
                bin_scr <= bus.bin_in;
                bcd_scr <= '0;
                cnt     <= '0;
            end else if (state == SHIFT) begin
                bcd_scr <= step[BW+BIN_WIDTH-1:BIN_WIDTH];
                bin_scr <= step[BIN_WIDTH-1:0];
                cnt     <= cnt + CW'(1);
            end
            // The result register only moves on the edge that enters DONE.
            if (last_step)
                bcd_res <= step[BW+BIN_WIDTH-1:BIN_WIDTH];
        end
    end

    assign bus.busy    = (state == SHIFT);
    assign bus.done    = (state == DONE);
    assign bus.bcd_out = bcd_res;
endmodule
